msg_pingpong_buffer: RTL and testbench

//  Double-banked (ping-pong) message buffer between the hi-speed protocol RX and TX engines; next generation of slave_device.
//  RX writes bytes into the fill bank. A correctly received message commits that bank to TX, and the banks swap.
//  TX reads the committed bank through a pipelined req/rdy port with configurable latency.

---
 rtl/msg_pingpong_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_msg_pingpong_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// msg_pingpong_buffer
//
// Double-banked (ping-pong) message buffer sitting between the RX and TX
// protocol engines. RX fills one bank while TX reads the other. When RX
// reports a correctly received message, the fill bank is committed to TX
// and the banks swap. If TX still holds an unreleased message, the new
// message is dropped instead, and a saturating drop counter records it.
//
// Ports
//   clk          system clock
//   rst_l        asynchronous active-low reset
//   wr_req       write request, one word per cycle
//   wr_addr      write address within the fill bank
//   wr_data      write data
//   wr_rdy       write done, 1-cycle pulse one cycle after wr_req
//   msg_end      end of RX message, 1-cycle pulse
//   msg_ok       qualifies msg_end: 1 = message correct
//   msg_len      byte count of the ending message
//   rd_req       read request, one accepted per cycle
//   rd_addr      read address within the committed bank
//   rd_data      read data, valid with rd_rdy, held otherwise
//   rd_rdy       read done, 1-cycle pulse RD_LAT cycles after rd_req
//   tx_release   TX finished with the committed bank, 1-cycle pulse
//   msg_avail    committed bank holds an unreleased message
//   msg_len_out  length of the committed message, clamped to DEPTH
//   overrun      1-cycle pulse: a correct message was dropped
//   drop_cnt     dropped-message count, saturates at 255
//   addr_err     sticky flag: an out-of-range write was seen
// ---------------------------------------------------------------------------
module msg_pingpong_buffer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_l,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,

    input  logic              msg_end,
    input  logic              msg_ok,
    input  logic [15:0]       msg_len,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_rdy,

    input  logic              tx_release,
    output logic              msg_avail,
    output logic [15:0]       msg_len_out,
    output logic              overrun,
    output logic [7:0]        drop_cnt,
    output logic              addr_err
);

    // Storage is one flat array: bank 0 occupies [0, DEPTH), bank 1
    // occupies [DEPTH, 2*DEPTH). DEPTH need not be a power of two, so the
    // bank base is added rather than concatenated.
    localparam int                MEM_AW     = $clog2(2 * DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_CMP  = (ADDR_W + 1)'(DEPTH);
    localparam logic [MEM_AW-1:0] BANK1_BASE = MEM_AW'(DEPTH);

    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    // fill_sel names the bank RX writes into; TX reads the other one.
    logic              fill_sel;

    logic              wr_in_range;
    logic              rd_in_range;
    logic [MEM_AW-1:0] wr_idx;
    logic [MEM_AW-1:0] rd_idx;
    logic [DATA_W-1:0] rd_word;

    logic              commit_ok;
    logic              slot_free;
    logic              do_swap;
    logic              do_drop;
    logic [15:0]       len_clamped;

    // -----------------------------------------------------------------------
    // Address decode
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here is given a value on every path, so no
    // latch can be inferred.
    always_comb begin
        wr_in_range = ({1'b0, wr_addr} < DEPTH_CMP);
        rd_in_range = ({1'b0, rd_addr} < DEPTH_CMP);
        wr_idx      = MEM_AW'(wr_addr) + (fill_sel ? BANK1_BASE : '0);
        rd_idx      = MEM_AW'(rd_addr) + (fill_sel ? '0 : BANK1_BASE);
        // Out-of-range reads return zero rather than a neighbouring word.
        rd_word     = rd_in_range ? mem[rd_idx] : '0;
    end

    // -----------------------------------------------------------------------
    // Commit / release decision
    // -----------------------------------------------------------------------
    // A release in the same cycle as a commit is applied first, so the
    // committed slot counts as free and the new message swaps in cleanly.
    always_comb begin
        commit_ok   = msg_end & msg_ok;
        slot_free   = ~msg_avail | tx_release;
        do_swap     = commit_ok & slot_free;
        do_drop     = commit_ok & ~slot_free;
        // msg_len wider than DEPTH is clamped to the bank size.
        len_clamped = ({16'b0, msg_len} < 32'(DEPTH)) ? msg_len : 16'(DEPTH);
    end

    // -----------------------------------------------------------------------
    // Storage
    // -----------------------------------------------------------------------
    // NOTE: the RAM array is deliberately left out of reset so it maps onto
    // block memory; its contents are undefined until written.
    // A write samples fill_sel in the same cycle as a simultaneous msg_end,
    // so the last word lands in the bank being committed.
    always_ff @(posedge clk) begin
        if (wr_req && wr_in_range) begin
            mem[wr_idx] <= wr_data;
        end
    end

    // -----------------------------------------------------------------------
    // Write handshake, bank control and status
    // -----------------------------------------------------------------------
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wr_rdy      <= 1'b0;
            addr_err    <= 1'b0;
            fill_sel    <= 1'b0;
            msg_avail   <= 1'b0;
            msg_len_out <= '0;
            overrun     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            // Every request is acknowledged, even one that is not stored.
            wr_rdy  <= wr_req;
            overrun <= 1'b0;

            if (wr_req && !wr_in_range) begin
                addr_err <= 1'b1;
            end

            if (do_swap) begin
                fill_sel    <= ~fill_sel;
                msg_avail   <= 1'b1;
                msg_len_out <= len_clamped;
            end else if (tx_release) begin
                // Harmless when msg_avail is already 0.
                msg_avail <= 1'b0;
            end

            // The dropped bank stays the fill bank; the next message simply
            // overwrites it.
            if (do_drop) begin
                overrun <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 8'd1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Read pipeline
    // -----------------------------------------------------------------------
    // The word is fetched in the request cycle, which fixes both the address
    // and the committed-bank select at that point; a later swap cannot
    // reach into a read already in flight. The remaining RD_LAT-1 stages
    // only delay the result. Each data stage loads only alongside a valid
    // token, so the last stage (rd_data) holds between reads.
    logic [RD_LAT-1:0] rd_vld;
    logic [DATA_W-1:0] rd_pipe [RD_LAT];

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rd_vld <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                rd_pipe[i] <= '0;
            end
        end else begin
            rd_vld[0] <= rd_req;
            if (rd_req) begin
                rd_pipe[0] <= rd_word;
            end
            for (int i = 1; i < RD_LAT; i++) begin
                rd_vld[i] <= rd_vld[i-1];
                if (rd_vld[i-1]) begin
                    rd_pipe[i] <= rd_pipe[i-1];
                end
            end
        end
    end

    assign rd_rdy  = rd_vld[RD_LAT-1];
    assign rd_data = rd_pipe[RD_LAT-1];

    // -----------------------------------------------------------------------
    // Protocol checks (ignored by synthesis)
    // -----------------------------------------------------------------------
    // An overrun can only be reported while a message is held.
    a_overrun_needs_avail : assert property (
        @(posedge clk) disable iff (!rst_l) overrun |-> msg_avail
    );

    // The saturating counter never wraps back to zero.
    a_drop_no_wrap : assert property (
        @(posedge clk) disable iff (!rst_l)
        (drop_cnt == 8'hFF) |=> (drop_cnt == 8'hFF)
    );

endmodule

// File: tb/tb_msg_pingpong_buffer.sv
// ---------------------------------------------------------------------------
// tb_msg_pingpong_buffer
//
// Directed vector table with hand-computed expectations, followed by
// randomized traffic, a drop-counter saturation run and a mid-flight reset.
// Every cycle is also compared against a behavioural model that keeps the
// two banks as plain arrays and outstanding reads as a time-stamped queue.
// ---------------------------------------------------------------------------
module tb_msg_pingpong_buffer;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 3;

    logic              clk = 1'b0;
    logic              rst_l;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_rdy;
    logic              msg_end;
    logic              msg_ok;
    logic [15:0]       msg_len;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_rdy;
    logic              tx_release;
    logic              msg_avail;
    logic [15:0]       msg_len_out;
    logic              overrun;
    logic [7:0]        drop_cnt;
    logic              addr_err;

    always #5 clk = ~clk;

    msg_pingpong_buffer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_l       (rst_l),
        .wr_req      (wr_req),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_rdy      (wr_rdy),
        .msg_end     (msg_end),
        .msg_ok      (msg_ok),
        .msg_len     (msg_len),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_rdy      (rd_rdy),
        .tx_release  (tx_release),
        .msg_avail   (msg_avail),
        .msg_len_out (msg_len_out),
        .overrun     (overrun),
        .drop_cnt    (drop_cnt),
        .addr_err    (addr_err)
    );

    // -----------------------------------------------------------------------
    // Bookkeeping
    // -----------------------------------------------------------------------
    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Stimulus and vector records
    // -----------------------------------------------------------------------
    typedef struct {
        logic        wr_req;
        logic [15:0] wr_addr;
        logic [7:0]  wr_data;
        logic        msg_end;
        logic        msg_ok;
        logic [15:0] msg_len;
        logic        rd_req;
        logic [15:0] rd_addr;
        logic        tx_release;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_wr_rdy;
        logic        e_rd_rdy;
        logic [7:0]  e_rd_data;
        logic        e_avail;
        logic [15:0] e_len;
        logic        e_ov;
        logic [7:0]  e_drop;
        logic        e_aerr;
    } vec_t;

    function automatic stim_t idle_stim();
        stim_t s;
        s.wr_req     = 1'b0;
        s.wr_addr    = '0;
        s.wr_data    = '0;
        s.msg_end    = 1'b0;
        s.msg_ok     = 1'b0;
        s.msg_len    = '0;
        s.rd_req     = 1'b0;
        s.rd_addr    = '0;
        s.tx_release = 1'b0;
        return s;
    endfunction

    function automatic vec_t v(int wr, int wa, int wd, int me, int mo, int ml,
                               int rr, int ra, int rel,
                               int ewr, int err, int erd, int eav, int elen,
                               int eov, int edr, int eae);
        vec_t x;
        x.s.wr_req     = 1'(wr);
        x.s.wr_addr    = 16'(wa);
        x.s.wr_data    = 8'(wd);
        x.s.msg_end    = 1'(me);
        x.s.msg_ok     = 1'(mo);
        x.s.msg_len    = 16'(ml);
        x.s.rd_req     = 1'(rr);
        x.s.rd_addr    = 16'(ra);
        x.s.tx_release = 1'(rel);
        x.e_wr_rdy     = 1'(ewr);
        x.e_rd_rdy     = 1'(err);
        x.e_rd_data    = 8'(erd);
        x.e_avail      = 1'(eav);
        x.e_len        = 16'(elen);
        x.e_ov         = 1'(eov);
        x.e_drop       = 8'(edr);
        x.e_aerr       = 1'(eae);
        return x;
    endfunction

    // -----------------------------------------------------------------------
    // Behavioural reference model
    // -----------------------------------------------------------------------
    // bank[b][a] holds the byte last written there, or -1 if never written.
    int bank [2][DEPTH];
    bit m_fill, m_avail, m_ov, m_aerr, m_wr_rdy;
    int m_len, m_drop;
    int m_last_rd;
    bit m_last_known;

    typedef struct {
        int due;
        int data;
    } rd_item_t;
    rd_item_t rdq[$];
    int cyc = 0;

    task automatic model_reset();
        m_fill       = 1'b0;
        m_avail      = 1'b0;
        m_ov         = 1'b0;
        m_aerr       = 1'b0;
        m_wr_rdy     = 1'b0;
        m_len        = 0;
        m_drop       = 0;
        m_last_rd    = 0;
        m_last_known = 1'b1;
        rdq.delete();
    endtask

    // Applies the rules for one clock edge, using pre-edge state.
    task automatic model_step(input stim_t s);
        m_wr_rdy = s.wr_req;
        if (s.wr_req) begin
            if (int'(s.wr_addr) < DEPTH) bank[m_fill][s.wr_addr] = int'(s.wr_data);
            else                         m_aerr = 1'b1;
        end
        if (s.rd_req) begin
            rd_item_t it;
            it.due  = cyc + RD_LAT;
            it.data = (int'(s.rd_addr) < DEPTH) ? bank[!m_fill][s.rd_addr] : 0;
            rdq.push_back(it);
        end
        m_ov = 1'b0;
        if (s.msg_end && s.msg_ok) begin
            if (!m_avail || s.tx_release) begin
                m_fill  = !m_fill;
                m_avail = 1'b1;
                m_len   = (int'(s.msg_len) < DEPTH) ? int'(s.msg_len) : DEPTH;
            end else begin
                m_ov = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end else if (s.tx_release) begin
            m_avail = 1'b0;
        end
    endtask

    task automatic model_check();
        bit exp_rdy;
        exp_rdy = (rdq.size() > 0) && (rdq[0].due == cyc);
        if (exp_rdy) begin
            rd_item_t it;
            it           = rdq.pop_front();
            m_last_known = (it.data >= 0);
            m_last_rd    = it.data;
        end
        check("model.wr_rdy",    32'(wr_rdy),      32'(m_wr_rdy));
        check("model.rd_rdy",    32'(rd_rdy),      32'(exp_rdy));
        if (m_last_known) check("model.rd_data", 32'(rd_data), 32'(m_last_rd));
        check("model.msg_avail", 32'(msg_avail),   32'(m_avail));
        check("model.msg_len",   32'(msg_len_out), 32'(m_len));
        check("model.overrun",   32'(overrun),     32'(m_ov));
        check("model.drop_cnt",  32'(drop_cnt),    32'(m_drop));
        check("model.addr_err",  32'(addr_err),    32'(m_aerr));
    endtask

    task automatic drive(input stim_t s);
        wr_req     = s.wr_req;
        wr_addr    = s.wr_addr;
        wr_data    = s.wr_data;
        msg_end    = s.msg_end;
        msg_ok     = s.msg_ok;
        msg_len    = s.msg_len;
        rd_req     = s.rd_req;
        rd_addr    = s.rd_addr;
        tx_release = s.tx_release;
    endtask

    // One clock cycle: drive, advance the model, clock, compare.
    task automatic apply(input stim_t s);
        drive(s);
        model_step(s);
        @(posedge clk);
        #1;
        cyc++;
        model_check();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".wr_rdy"},    32'(wr_rdy),      32'd0);
        check({tag, ".rd_rdy"},    32'(rd_rdy),      32'd0);
        check({tag, ".rd_data"},   32'(rd_data),     32'd0);
        check({tag, ".msg_avail"}, 32'(msg_avail),   32'd0);
        check({tag, ".msg_len"},   32'(msg_len_out), 32'd0);
        check({tag, ".overrun"},   32'(overrun),     32'd0);
        check({tag, ".drop_cnt"},  32'(drop_cnt),    32'd0);
        check({tag, ".addr_err"},  32'(addr_err),    32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    initial begin
        vec_t  tbl[$];
        stim_t s;

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < DEPTH; a++) bank[b][a] = -1;

        // Directed table. Expected columns: wr_rdy rd_rdy rd_data avail len ov drop aerr,
        // observed just after the edge that samples the row. Reads return RD_LAT=3
        // cycles later, i.e. in the check of the row two below the request.
        //       wr wa  wd    me mo ml  rr ra rel | ewr err erd  eav elen eov edr eae
        tbl.push_back(v(1, 0, 'hA0, 0, 0, 0,  0, 0, 0,  1, 0, 'h00, 0, 0,  0, 0, 0)); // 0
        tbl.push_back(v(1, 1, 'hA1, 0, 0, 0,  0, 0, 0,  1, 0, 'h00, 0, 0,  0, 0, 0)); // 1
        tbl.push_back(v(1, 2, 'hA2, 0, 0, 0,  0, 0, 0,  1, 0, 'h00, 0, 0,  0, 0, 0)); // 2
        tbl.push_back(v(1, 3, 'hA3, 1, 1, 4,  0, 0, 0,  1, 0, 'h00, 1, 4,  0, 0, 0)); // 3 last word + commit
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0, 0,  0, 0, 'h00, 1, 4,  0, 0, 0)); // 4
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 1, 0,  0, 0, 'h00, 1, 4,  0, 0, 0)); // 5
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 2, 0,  0, 1, 'hA0, 1, 4,  0, 0, 0)); // 6
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 3, 0,  0, 1, 'hA1, 1, 4,  0, 0, 0)); // 7
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hA2, 1, 4,  0, 0, 0)); // 8
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hA3, 1, 4,  0, 0, 0)); // 9
        tbl.push_back(v(1, 0, 'hB0, 0, 0, 0,  0, 0, 0,  1, 0, 'hA3, 1, 4,  0, 0, 0)); // 10
        tbl.push_back(v(0, 0, 0,    1, 1, 1,  0, 0, 0,  0, 0, 'hA3, 1, 4,  1, 1, 0)); // 11 overrun
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0, 0,  0, 0, 'hA3, 1, 4,  0, 1, 0)); // 12
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 0, 'hA3, 1, 4,  0, 1, 0)); // 13
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hA0, 1, 4,  0, 1, 0)); // 14 msg1 intact
        tbl.push_back(v(1, 0, 'hC0, 0, 0, 0,  0, 0, 0,  1, 0, 'hA0, 1, 4,  0, 1, 0)); // 15
        tbl.push_back(v(1, 1, 'hC1, 0, 0, 0,  0, 0, 0,  1, 0, 'hA0, 1, 4,  0, 1, 0)); // 16
        tbl.push_back(v(0, 0, 0,    1, 1, 2,  0, 0, 1,  0, 0, 'hA0, 1, 2,  0, 1, 0)); // 17 release+commit
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0, 0,  0, 0, 'hA0, 1, 2,  0, 1, 0)); // 18
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 1, 0,  0, 0, 'hA0, 1, 2,  0, 1, 0)); // 19
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hC0, 1, 2,  0, 1, 0)); // 20
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hC1, 1, 2,  0, 1, 0)); // 21
        tbl.push_back(v(1, 16, 'hEE,0, 0, 0,  0, 0, 0,  1, 0, 'hC1, 1, 2,  0, 1, 1)); // 22 bad write
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 16,0,  0, 0, 'hC1, 1, 2,  0, 1, 1)); // 23 bad read
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 0, 'hC1, 1, 2,  0, 1, 1)); // 24
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'h00, 1, 2,  0, 1, 1)); // 25
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 0, 0,  0, 0, 'h00, 1, 2,  0, 1, 1)); // 26
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 0, 'h00, 1, 2,  0, 1, 1)); // 27
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hC0, 1, 2,  0, 1, 1)); // 28 no alias
        tbl.push_back(v(0, 0, 0,    1, 0, 9,  0, 0, 0,  0, 0, 'hC0, 1, 2,  0, 1, 1)); // 29 bad msg
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 1,  0, 0, 'hC0, 0, 2,  0, 1, 1)); // 30 release
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 1,  0, 0, 'hC0, 0, 2,  0, 1, 1)); // 31 ignored
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 1, 0,  0, 0, 'hC0, 0, 2,  0, 1, 1)); // 32
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 0, 'hC0, 0, 2,  0, 1, 1)); // 33
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hC1, 0, 2,  0, 1, 1)); // 34
        tbl.push_back(v(0, 0, 0,    1, 1, 40, 0, 0, 0,  0, 0, 'hC1, 1, 16, 0, 1, 1)); // 35 clamp
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  1, 2, 0,  0, 0, 'hC1, 1, 16, 0, 1, 1)); // 36
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 0, 'hC1, 1, 16, 0, 1, 1)); // 37
        tbl.push_back(v(0, 0, 0,    0, 0, 0,  0, 0, 0,  0, 1, 'hA2, 1, 16, 0, 1, 1)); // 38

        // Reset state.
        rst_l = 1'b0;
        drive(idle_stim());
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_l = 1'b1;

        // Directed vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i].s);
            check($sformatf("v%0d.wr_rdy", i),   32'(wr_rdy),      32'(tbl[i].e_wr_rdy));
            check($sformatf("v%0d.rd_rdy", i),   32'(rd_rdy),      32'(tbl[i].e_rd_rdy));
            check($sformatf("v%0d.rd_data", i),  32'(rd_data),     32'(tbl[i].e_rd_data));
            check($sformatf("v%0d.avail", i),    32'(msg_avail),   32'(tbl[i].e_avail));
            check($sformatf("v%0d.len", i),      32'(msg_len_out), 32'(tbl[i].e_len));
            check($sformatf("v%0d.overrun", i),  32'(overrun),     32'(tbl[i].e_ov));
            check($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt),    32'(tbl[i].e_drop));
            check($sformatf("v%0d.addr_err", i), 32'(addr_err),    32'(tbl[i].e_aerr));
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            s            = idle_stim();
            s.wr_req     = ($urandom_range(0, 1) == 1);
            s.wr_addr    = 16'($urandom_range(0, DEPTH));
            s.wr_data    = 8'($urandom);
            s.msg_end    = ($urandom_range(0, 9) == 0);
            s.msg_ok     = ($urandom_range(0, 3) != 0);
            s.msg_len    = 16'($urandom_range(0, 40));
            s.rd_req     = ($urandom_range(0, 1) == 1);
            s.rd_addr    = 16'($urandom_range(0, DEPTH));
            s.tx_release = ($urandom_range(0, 9) == 0);
            apply(s);
        end

        // Saturation: one commit to hold a message, then many more drops.
        s          = idle_stim();
        s.msg_end  = 1'b1;
        s.msg_ok   = 1'b1;
        s.msg_len  = 16'd5;
        for (int i = 0; i < 260; i++) apply(s);
        check("drop_sat", 32'(drop_cnt), 32'd255);
        apply(s);
        check("drop_sat_hold", 32'(drop_cnt), 32'd255);
        apply(idle_stim());

        // Mid-flight reset with two reads outstanding.
        s         = idle_stim();
        s.rd_req  = 1'b1;
        s.rd_addr = 16'd1;
        apply(s);
        s.rd_addr = 16'd2;
        apply(s);
        drive(idle_stim());
        #2;
        rst_l = 1'b0;
        #1;
        check_all_zero("midrst");
        model_reset();
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            check("midrst.rd_rdy_held", 32'(rd_rdy), 32'd0);
        end
        @(negedge clk);
        rst_l = 1'b1;
        for (int i = 0; i < 6; i++) apply(idle_stim());
        check_all_zero("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
